// File: rtl/micro_sequencer.sv
// Microcoded control sequencer: fixed FETCH word, then up to MAX_STEPS microcode words per opcode.
// Holds a writable microcode store indexed by {opcode, step}.
module micro_sequencer #(
  parameter int unsigned          CW_WIDTH     = 21,
  parameter int unsigned          OPCODE_WIDTH = 4,
  parameter int unsigned          MAX_STEPS    = 8,
  parameter logic [CW_WIDTH-1:0]  FETCH_WORD   = 21'h00200F,
  localparam int unsigned         SW           = $clog2(MAX_STEPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hlt,
  input  logic [OPCODE_WIDTH-1:0]    opcode,
  input  logic                       ucode_we,
  input  logic [OPCODE_WIDTH+SW-1:0] ucode_addr,
  input  logic [CW_WIDTH:0]          ucode_wdata,
  output logic [CW_WIDTH-1:0]        control_word,
  output logic [SW:0]                T,
  output logic                       instr_done,
  output logic                       halted
);

  localparam int unsigned    Depth    = 2 ** (OPCODE_WIDTH + SW);
  localparam logic [SW-1:0]  LastStep = SW'(MAX_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalted} state_e;

  state_e                    state_q, state_d;
  logic [SW-1:0]             step_q, step_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;

  logic [CW_WIDTH:0]         ucode_mem [Depth];
  logic [OPCODE_WIDTH-1:0]   rd_op;
  logic [OPCODE_WIDTH+SW-1:0] rd_addr;
  logic [CW_WIDTH:0]         ucode_word;
  logic                      exec_last;

  // Not reset: microcode survives a sequencer reset and can be loaded while reset is held.
  always_ff @(posedge clk) begin
    if (ucode_we) begin
      ucode_mem[ucode_addr] <= ucode_wdata;
    end
  end

  // Step 0 looks up the live opcode; later steps use the opcode latched at step 0.
  assign rd_op      = (step_q == '0) ? opcode : op_q;
  assign rd_addr    = {rd_op, step_q};
  assign ucode_word = ucode_mem[rd_addr];
  assign exec_last  = ucode_word[CW_WIDTH] || (step_q == LastStep);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    op_d         = op_q;
    control_word = '0;
    T            = '0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        control_word = FETCH_WORD;
        step_d       = '0;
        state_d      = StExec;
      end
      StExec: begin
        control_word = ucode_word[CW_WIDTH-1:0];
        T            = {1'b0, step_q} + (SW+1)'(1);
        if (step_q == '0) begin
          op_d = opcode;
        end
        if (exec_last) begin
          instr_done = 1'b1;
          step_d     = '0;
          state_d    = hlt ? StHalted : StFetch;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      StHalted: begin
        halted = 1'b1;
        if (!hlt) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
    end
  end

endmodule
